// File: rtl/rst_seq.sv
// Reset sequencer for the Wishbone clock domain: waits for a filtered PLL lock,
// then releases NUM_RST active-high resets one at a time in index order.
module rst_seq #(
  parameter int NUM_RST     = 4,
  parameter int STRETCH     = 16,
  parameter int LOCK_FILTER = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               wb_clk_i,
  input  logic               rst_n_pad_i,
  input  logic               pll_lock_i,
  input  logic               soft_rst_i,
  output logic [NUM_RST-1:0] rst_o,
  output logic               ready_o,
  output logic [1:0]         state_o
);

  localparam int LCW = $clog2(LOCK_FILTER) + 1;
  localparam int SCW = $clog2(STRETCH) + 1;
  localparam int IW  = $clog2(NUM_RST) + 1;

  localparam logic [LCW-1:0] LC_LAST  = LCW'(LOCK_FILTER - 1);
  localparam logic [SCW-1:0] SC_LAST  = SCW'(STRETCH - 1);
  localparam logic [IW-1:0]  IDX_LAST = IW'(NUM_RST - 1);

  typedef enum logic [1:0] {
    S_HOLD      = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_RELEASE   = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] rst_sync;
  logic [SYNC_STAGES-1:0] lock_sync;
  logic                   rst_int_n;
  logic                   lock_s;
  logic                   abort;

  state_t             state_q, state_d;
  logic [LCW-1:0]     lock_cnt_q, lock_cnt_d;
  logic [SCW-1:0]     str_cnt_q, str_cnt_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [NUM_RST-1:0] rst_q, rst_d;
  logic               ready_q, ready_d;

  // Both chains clear asynchronously so the pad reset and a stale lock
  // cannot leak into the first cycles after release.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the chain into one stage.
  always_ff @(posedge wb_clk_i or negedge rst_n_pad_i) begin
    if (!rst_n_pad_i) begin
      rst_sync  <= '0;
      lock_sync <= '0;
    end else begin
      rst_sync  <= {rst_sync[SYNC_STAGES-2:0], 1'b1};
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_lock_i};
    end
  end

  assign rst_int_n = rst_sync[SYNC_STAGES-1];
  assign lock_s    = lock_sync[SYNC_STAGES-1];
  assign abort     = !lock_s || soft_rst_i;

  always_ff @(posedge wb_clk_i or negedge rst_n_pad_i) begin
    if (!rst_n_pad_i) begin
      state_q    <= S_HOLD;
      lock_cnt_q <= '0;
      str_cnt_q  <= '0;
      idx_q      <= '0;
      rst_q      <= '1;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      str_cnt_q  <= str_cnt_d;
      idx_q      <= idx_d;
      rst_q      <= rst_d;
      ready_q    <= ready_d;
    end
  end

  // NOTE: every output of this block gets a default first so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    str_cnt_d  = str_cnt_q;
    idx_d      = idx_q;
    rst_d      = rst_q;
    ready_d    = ready_q;

    unique case (state_q)
      S_HOLD: begin
        if (rst_int_n) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (lock_s && !soft_rst_i) begin
          lock_cnt_d = lock_cnt_q + 1'b1;
          if (lock_cnt_q == LC_LAST) begin
            state_d   = S_RELEASE;
            idx_d     = '0;
            str_cnt_d = '0;
          end
        end else begin
          lock_cnt_d = '0;
        end
      end
      S_RELEASE, S_RUN: begin
        if (abort) begin
          state_d    = S_WAIT_LOCK;
          lock_cnt_d = '0;
          str_cnt_d  = '0;
          idx_d      = '0;
          rst_d      = '1;
          ready_d    = 1'b0;
        end else if (state_q == S_RELEASE) begin
          if (str_cnt_q == SC_LAST) begin
            // Shifting in a zero clears bit idx and keeps the ones contiguous.
            rst_d     = rst_q << 1;
            idx_d     = idx_q + 1'b1;
            str_cnt_d = '0;
            if (idx_q == IDX_LAST) begin
              state_d = S_RUN;
              ready_d = 1'b1;
            end
          end else begin
            str_cnt_d = str_cnt_q + 1'b1;
          end
        end
      end
    endcase
  end

  assign rst_o   = rst_q;
  assign ready_o = ready_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq: power-up timing, lock filter, lock loss, soft
// reset, async reset and a small-parameter instance.
module tb_rst_seq;

  logic       wb_clk_i    = 1'b0;
  logic       rst_n_pad_i = 1'b1;
  logic       pll_lock_i  = 1'b1;
  logic       soft_rst_i  = 1'b0;
  logic [3:0] rst_o;
  logic       ready_o;
  logic [1:0] state_o;
  logic [0:0] rst_p;
  logic       ready_p;
  logic [1:0] state_p;
  logic [6:0] obs;
  logic [3:0] obs_p;
  logic [3:0] inv;
  logic       mon_en = 1'b0;
  int         ecnt = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  rst_seq dut (
    .wb_clk_i(wb_clk_i), .rst_n_pad_i(rst_n_pad_i), .pll_lock_i(pll_lock_i),
    .soft_rst_i(soft_rst_i), .rst_o(rst_o), .ready_o(ready_o), .state_o(state_o)
  );

  rst_seq #(.NUM_RST(1), .STRETCH(2), .LOCK_FILTER(1), .SYNC_STAGES(3)) dut_p (
    .wb_clk_i(wb_clk_i), .rst_n_pad_i(rst_n_pad_i), .pll_lock_i(pll_lock_i),
    .soft_rst_i(soft_rst_i), .rst_o(rst_p), .ready_o(ready_p), .state_o(state_p)
  );

  assign obs   = {rst_o, ready_o, state_o};
  assign obs_p = {rst_p, ready_p, state_p};

  // Edge n is the n-th rising edge after rst_n_pad_i rises.
  always @(posedge wb_clk_i or negedge rst_n_pad_i) begin
    if (!rst_n_pad_i) ecnt <= 0;
    else              ecnt <= ecnt + 1;
  end

  // rst_o must always read as ones from the top bit down, zeros below.
  always @(negedge wb_clk_i) begin
    if (mon_en) begin
      inv = ~rst_o;
      n_tests++;
      if ((inv & (inv + 4'd1)) !== 4'd0) begin
        n_fail++;
        $display("FAIL contiguity t=%0t rst_o=%b required contiguous ones from top", $time, rst_o);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic at_edge(input int n);
    while (ecnt < n) begin
      @(posedge wb_clk_i);
      #1;
    end
  endtask

  task automatic hold_reset();
    @(negedge wb_clk_i);
    rst_n_pad_i = 1'b0;
    pll_lock_i  = 1'b1;
    soft_rst_i  = 1'b0;
    repeat (2) @(negedge wb_clk_i);
  endtask

  task automatic release_reset();
    @(negedge wb_clk_i);
    rst_n_pad_i = 1'b1;
  endtask

  task automatic test_reset();
    hold_reset();
    mon_en = 1'b1;
    n_tests++;
    if (obs !== 7'b1111_0_00) begin
      n_fail++; $display("FAIL reset_main obs=%b required=%b", obs, 7'b1111_0_00);
    end
    n_tests++;
    if (obs_p !== 4'b1_0_00) begin
      n_fail++; $display("FAIL reset_param obs=%b required=%b", obs_p, 4'b1_0_00);
    end
  endtask

  task automatic test_power_up();
    int          e    [10] = '{2, 3, 10, 11, 26, 27, 43, 59, 74, 75};
    logic [6:0]  exp_v[10] = '{7'b1111_0_00, 7'b1111_0_01, 7'b1111_0_01, 7'b1111_0_10,
                               7'b1111_0_10, 7'b1110_0_10, 7'b1100_0_10, 7'b1000_0_10,
                               7'b1000_0_10, 7'b0000_1_11};
    hold_reset();
    release_reset();
    for (int i = 0; i < 10; i++) begin
      at_edge(e[i]);
      n_tests++;
      if (obs !== exp_v[i]) begin
        n_fail++; $display("FAIL power_up_e%0d obs=%b required=%b", e[i], obs, exp_v[i]);
      end
    end
  endtask

  task automatic test_lock_filter();
    int          e    [5] = '{8, 16, 17, 32, 33};
    logic [6:0]  exp_v[5] = '{7'b1111_0_01, 7'b1111_0_01, 7'b1111_0_10,
                              7'b1111_0_10, 7'b1110_0_10};
    hold_reset();
    release_reset();
    at_edge(6);
    @(negedge wb_clk_i) pll_lock_i = 1'b0;
    at_edge(7);
    @(negedge wb_clk_i) pll_lock_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      at_edge(e[i]);
      n_tests++;
      if (obs !== exp_v[i]) begin
        n_fail++; $display("FAIL lock_filter_e%0d obs=%b required=%b", e[i], obs, exp_v[i]);
      end
    end
  endtask

  task automatic test_lock_loss();
    int          e    [8] = '{82, 83, 99, 100, 115, 116, 132, 164};
    logic [6:0]  exp_v[8] = '{7'b0000_1_11, 7'b1111_0_01, 7'b1111_0_01, 7'b1111_0_10,
                              7'b1111_0_10, 7'b1110_0_10, 7'b1100_0_10, 7'b0000_1_11};
    hold_reset();
    release_reset();
    at_edge(80);
    @(negedge wb_clk_i) pll_lock_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (e[i] == 99) begin
        // lock returns between edges 90 and 91
      end
      at_edge(e[i]);
      n_tests++;
      if (obs !== exp_v[i]) begin
        n_fail++; $display("FAIL lock_loss_e%0d obs=%b required=%b", e[i], obs, exp_v[i]);
      end
      if (e[i] == 83) begin
        at_edge(90);
        @(negedge wb_clk_i) pll_lock_i = 1'b1;
      end
    end
  endtask

  task automatic test_soft_reset();
    int          e    [6] = '{45, 46, 53, 54, 70, 118};
    logic [6:0]  exp_v[6] = '{7'b1100_0_10, 7'b1111_0_01, 7'b1111_0_01, 7'b1111_0_10,
                              7'b1110_0_10, 7'b0000_1_11};
    hold_reset();
    release_reset();
    for (int i = 0; i < 6; i++) begin
      at_edge(e[i]);
      n_tests++;
      if (obs !== exp_v[i]) begin
        n_fail++; $display("FAIL soft_reset_e%0d obs=%b required=%b", e[i], obs, exp_v[i]);
      end
      if (e[i] == 45) @(negedge wb_clk_i) soft_rst_i = 1'b1;
      if (e[i] == 46) @(negedge wb_clk_i) soft_rst_i = 1'b0;
    end
  endtask

  task automatic test_async_reset();
    int          e    [3] = '{26, 27, 75};
    logic [6:0]  exp_v[3] = '{7'b1111_0_10, 7'b1110_0_10, 7'b0000_1_11};
    hold_reset();
    release_reset();
    at_edge(62);
    n_tests++;
    if (obs !== 7'b1000_0_10) begin
      n_fail++; $display("FAIL async_pre obs=%b required=%b", obs, 7'b1000_0_10);
    end
    #2 rst_n_pad_i = 1'b0;
    #1;
    n_tests++;
    if (obs !== 7'b1111_0_00) begin
      n_fail++; $display("FAIL async_now obs=%b required=%b", obs, 7'b1111_0_00);
    end
    release_reset();
    for (int i = 0; i < 3; i++) begin
      at_edge(e[i]);
      n_tests++;
      if (obs !== exp_v[i]) begin
        n_fail++; $display("FAIL async_rerun_e%0d obs=%b required=%b", e[i], obs, exp_v[i]);
      end
    end
  endtask

  task automatic test_param_sweep();
    int          e    [5] = '{3, 4, 5, 6, 7};
    logic [3:0]  exp_v[5] = '{4'b1_0_00, 4'b1_0_01, 4'b1_0_10, 4'b1_0_10, 4'b0_1_11};
    hold_reset();
    release_reset();
    for (int i = 0; i < 5; i++) begin
      at_edge(e[i]);
      n_tests++;
      if (obs_p !== exp_v[i]) begin
        n_fail++; $display("FAIL param_sweep_e%0d obs=%b required=%b", e[i], obs_p, exp_v[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_lock_filter();
    test_lock_loss();
    test_soft_reset();
    test_async_reset();
    test_param_sweep();
    repeat (2) @(negedge wb_clk_i);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
